// File: rtl/seq_divider_16by8.sv
// Iterative restoring divider, one quotient bit per clock over a start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up on load).
module seq_divider_16by8 #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W   = $clog2(DIVIDEND_W);
  localparam int unsigned REM_W   = DIVISOR_W + 1;
  localparam int unsigned TRIAL_W = REM_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [DIVISOR_W-1:0]  rem, rem_next;
  logic [DIVISOR_W-1:0]  dsr, dsr_next;
  logic [DIVIDEND_W-1:0] quo, quo_next;
  logic                  zero_div, zero_div_next;
  logic [DIVIDEND_W-1:0] quotient_next;
  logic [DIVISOR_W-1:0]  remainder_next;
  logic                  div_by_zero_next, busy_next, done_next;

  logic [REM_W-1:0]      rem_shift;
  logic [TRIAL_W-1:0]    trial;
  logic                  no_borrow;
  logic [DIVISOR_W-1:0]  rem_iter;
  logic [DIVIDEND_W-1:0] quo_shift;
  logic [DIVIDEND_W-1:0] a_mag, q_final;
  logic [DIVISOR_W-1:0]  b_mag, r_final;

  // One restoring step: shift {rem,quo} left, trial-subtract, keep on no borrow
  assign rem_shift = {rem, quo[DIVIDEND_W-1]};
  assign trial     = {1'b0, rem_shift} - TRIAL_W'(dsr);
  assign no_borrow = ~trial[TRIAL_W-1];
  assign rem_iter  = no_borrow ? DIVISOR_W'(trial) : DIVISOR_W'(rem_shift);
  assign quo_shift = {quo[DIVIDEND_W-2:0], no_borrow};

`ifdef DIVIDER_SIGNED_EN
  logic q_neg, q_neg_next, r_neg, r_neg_next;

  assign a_mag   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign b_mag   = divisor[DIVISOR_W-1]   ? -divisor  : divisor;
  assign q_final = q_neg ? -quo_shift : quo_shift;
  assign r_final = r_neg ? -rem_iter  : rem_iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      q_neg <= q_neg_next;
      r_neg <= r_neg_next;
    end
  end

  always_comb begin
    q_neg_next = q_neg;
    r_neg_next = r_neg;
    if (state != RUN && start) begin
      q_neg_next = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
      r_neg_next = dividend[DIVIDEND_W-1];
    end
  end
`else
  assign a_mag   = dividend;
  assign b_mag   = divisor;
  assign q_final = quo_shift;
  assign r_final = rem_iter;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dsr         <= '0;
      quo         <= '0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rem         <= rem_next;
      dsr         <= dsr_next;
      quo         <= quo_next;
      zero_div    <= zero_div_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= div_by_zero_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

  // Zero divisor still spends one cycle in RUN so busy/done timing stays uniform
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    rem_next         = rem;
    dsr_next         = dsr;
    quo_next         = quo;
    zero_div_next    = zero_div;
    quotient_next    = quotient;
    remainder_next   = remainder;
    div_by_zero_next = div_by_zero;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next    = RUN;
          cnt_next      = '0;
          rem_next      = '0;
          quo_next      = a_mag;
          dsr_next      = b_mag;
          zero_div_next = (divisor == '0);
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (zero_div) begin
          state_next       = DONE;
          quotient_next    = '1;
          remainder_next   = '0;
          div_by_zero_next = 1'b1;
        end else begin
          rem_next = rem_iter;
          quo_next = quo_shift;
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIVIDEND_W - 1)) begin
            state_next       = DONE;
            quotient_next    = q_final;
            remainder_next   = r_final;
            div_by_zero_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Scoreboard bench for seq_divider_16by8: driver pushes expected results, monitor checks on done.
module tb_seq_divider_16by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seq_divider_16by8 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare whenever the DUT presents done
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d q=%h r=%h dz=%b", cyc, quotient, remainder, div_by_zero);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          errors++;
          $display("FAIL result got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                   quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency done at edge %0d expected edge %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, want);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_bit("done_timeout", done, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle
  task automatic issue(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] q, input logic [7:0] r, input logic dz);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q = q; e.r = r; e.dz = dz;
    e.cyc = cyc + 1 + (dz ? 1 : 16);
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    check_bit("busy_after_accept", busy, 1'b1);
    check_bit("no_done_after_accept", done, 1'b0);
    wait_done();
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sd;
    e.cyc = 0;
    sa = 0;
    sd = 1;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = 8'h00; e.dz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sd = int'($signed(b));
`else
      sa = int'(a);
      sd = int'(b);
`endif
      e.q  = 16'(sa / sd);
      e.r  = 8'(sa % sd);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  initial begin
    exp_t        m;
    logic [15:0] ra;
    logic [7:0]  rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_dz", div_by_zero, 1'b0);
    checks++;
    if (quotient !== 16'h0 || remainder !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs got q=%h r=%h expected 0 0", quotient, remainder);
    end
    rst = 1'b0;
    @(negedge clk);

    issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    @(negedge clk);
`ifdef DIVIDER_SIGNED_EN
    issue(16'hFFFF, 8'hFF, 16'h0001, 8'h00, 1'b0);
`else
    issue(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
`endif
    @(negedge clk);
    issue(16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0);
    @(negedge clk);
    issue(16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1);
    @(negedge clk);
    check_bit("done_one_cycle", done, 1'b0);
    check_bit("dz_holds", div_by_zero, 1'b1);

    // Ignored start while busy, then back-to-back start in the DONE cycle
    begin
      exp_t e;
      start = 1'b1; dividend = 16'd500; divisor = 8'd3;
      e.q = 16'd166; e.r = 8'd2; e.dz = 1'b0; e.cyc = cyc + 17;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; dividend = 16'd9; divisor = 8'd2;
      @(negedge clk);
      start = 1'b0; dividend = 16'd0; divisor = 8'd0;
      wait_done();
      issue(16'd9, 8'd2, 16'd4, 8'd1, 1'b0);
    end

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    checks++;
    if (quotient !== 16'h0 || remainder !== 8'h0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got q=%h r=%h dz=%b expected 0 0 0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_bit("idle_after_abort", busy, 1'b0);
    issue(16'd200, 8'd10, 16'd20, 8'd0, 1'b0);
    @(negedge clk);

`ifdef DIVIDER_SIGNED_EN
    issue(16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0);
    @(negedge clk);
    issue(16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
    @(negedge clk);
`endif

    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      m  = model(ra, rb);
      issue(ra, rb, m.q, m.r, m.dz);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
